// File: rtl/comp_pkg.sv
// Shared types and cascade resolution for the sliced magnitude comparator.
package comp_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } res_t;

  // Equal operands resolve through the 7485 cascade inputs.
  function automatic res_t cascade_resolve(input logic lin, input logic ein, input logic gin);
    res_t r;
    r = '0;
    if (ein) begin
      r.eq = 1'b1;
    end else if (gin && !lin) begin
      r.gt = 1'b1;
    end else if (lin && !gin) begin
      r.lt = 1'b1;
    end else if (!lin && !gin) begin
      r.lt = 1'b1;
      r.gt = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mag_comp_if.sv
// Handshake and operand/result bundle for seq_mag_comp.
interface seq_mag_comp_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             lin;
  logic             ein;
  logic             gin;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, a, b, signed_mode, lin, ein, gin,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, a, b, signed_mode, lin, ein, gin,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/slice_cmp.sv
// Combinational 7485-equivalent magnitude compare of one slice, no cascade inputs.
module slice_cmp #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);
  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);
endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: SLICE bits per clock, MSB slice first, early exit
// on the first unequal slice, 7485 cascade resolution when all slices match.
module seq_mag_comp
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_mag_comp_if.slave bus
);
  localparam int unsigned NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("seq_mag_comp: WIDTH must be a non-zero multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             lin_q, lin_d, ein_q, ein_d, gin_q, gin_d;
  res_t             res_q, res_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [SLICE-1:0] a_sl, b_sl;
  logic             s_lt, s_eq, s_gt;
  int unsigned      shamt;

  // Signed compare is unsigned compare with the sign bits inverted; done at capture.
  always_comb begin
    flip            = '0;
    flip[WIDTH-1]   = bus.signed_mode;
  end

  always_comb begin
    shamt = (NSLICE - 1 - 32'(k_q)) * SLICE;
    a_sh  = a_q >> shamt;
    b_sh  = b_q >> shamt;
    a_sl  = a_sh[SLICE-1:0];
    b_sl  = b_sh[SLICE-1:0];
  end

  slice_cmp #(
    .SLICE(SLICE)
  ) u_slice_cmp (
    .a (a_sl),
    .b (b_sl),
    .lt(s_lt),
    .eq(s_eq),
    .gt(s_gt)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    lin_d   = lin_q;
    ein_d   = ein_q;
    gin_d   = gin_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a ^ flip;
          b_d     = bus.b ^ flip;
          lin_d   = bus.lin;
          ein_d   = bus.ein;
          gin_d   = bus.gin;
          res_d   = '0;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!s_eq) begin
          res_d   = '{lt: s_lt, eq: 1'b0, gt: s_gt};
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (k_q == KW'(NSLICE - 1)) begin
          res_d   = cascade_resolve(lin_q, ein_q, gin_q);
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lin_q   <= 1'b0;
      ein_q   <= 1'b0;
      gin_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lin_q   <= lin_d;
      ein_q   <= ein_d;
      gin_q   <= gin_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.lt   = res_q.lt;
  assign bus.eq   = res_q.eq;
  assign bus.gt   = res_q.gt;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed bench for seq_mag_comp at WIDTH=8, SLICE=4: vector table plus handshake/reset sequences.
module tb_seq_mag_comp;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_mag_comp_if #(.WIDTH(8)) bus ();

  seq_mag_comp #(
    .WIDTH(8),
    .SLICE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic       lin;
    logic       ein;
    logic       gin;
    logic [2:0] res;  // {lt, eq, gt}
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int res3();
    return int'({bus.lt, bus.eq, bus.gt});
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic lin, input logic ein, input logic gin);
    bus.start       = 1'b1;
    bus.a           = a;
    bus.b           = b;
    bus.signed_mode = sm;
    bus.lin         = lin;
    bus.ein         = ein;
    bus.gin         = gin;
  endtask

  // Called right after driving start at a negedge; returns negedges until done is seen.
  task automatic wait_done(input bit hold, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) bus.start = 1'b0;
      if (hold && lat == 1) begin
        bus.a = 8'hff;
        bus.b = 8'h00;
      end
    end while (!bus.done && lat < 12);
    bus.start = 1'b0;
  endtask

  initial begin
    int lat;
    int dones;
    vecs[0]  = '{"fe_ff_lt",   8'hfe, 8'hff, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 3};
    vecs[1]  = '{"00_ff_lt",   8'h00, 8'hff, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 2};
    vecs[2]  = '{"08_03_gt",   8'h08, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3};
    vecs[3]  = '{"30_2f_gt",   8'h30, 8'h2f, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 2};
    vecs[4]  = '{"casc_010",   8'hff, 8'hff, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 3};
    vecs[5]  = '{"casc_001",   8'hff, 8'hff, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 3};
    vecs[6]  = '{"casc_100",   8'hff, 8'hff, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 3};
    vecs[7]  = '{"casc_101",   8'hff, 8'hff, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3};
    vecs[8]  = '{"casc_000",   8'hff, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 3};
    vecs[9]  = '{"80_7f_sgn",  8'h80, 8'h7f, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 2};
    vecs[10] = '{"80_7f_uns",  8'h80, 8'h7f, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 2};

    rst = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_res", res3(), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].lin, vecs[i].ein, vecs[i].gin);
      wait_done(1'b0, lat);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_res"}, res3(), int'(vecs[i].res));
      chk({vecs[i].name, "_busy"}, int'(bus.busy), 0);
      @(negedge clk);
      chk({vecs[i].name, "_pulse"}, int'(bus.done), 0);
      chk({vecs[i].name, "_hold"}, res3(), int'(vecs[i].res));
    end

    // Signed -1 vs +1 decides on the MSB slice.
    drive(8'hff, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, lat);
    chk("sgn_m1_p1_lat", lat, 2);
    chk("sgn_m1_p1_res", res3(), 3'b100);
    @(negedge clk);

    // start held through RUN while operands change: result from captured 0x12 < 0x13.
    drive(8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(1'b1, lat);
    chk("hold_lat", lat, 3);
    chk("hold_res", res3(), 3'b100);
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("hold_single_done", dones, 0);
    chk("hold_busy_after", int'(bus.busy), 0);

    // Back-to-back: second start issued in the done cycle of the first.
    drive(8'h30, 8'h2f, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, lat);
    chk("b2b_first_res", res3(), 3'b001);
    drive(8'hfe, 8'hff, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, lat);
    chk("b2b_second_lat", lat, 3);
    chk("b2b_second_res", res3(), 3'b100);
    @(negedge clk);

    // Reset one cycle into RUN kills the compare and clears the held lt.
    drive(8'hff, 8'hff, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst_run_busy_pre", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_run_busy", int'(bus.busy), 0);
    chk("rst_run_res", res3(), 0);
    dones = int'(bus.done);
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("rst_run_no_done", dones, 0);
    drive(8'h00, 8'hff, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, lat);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_res", res3(), 3'b100);
    @(negedge clk);

    // rst and start together: start dropped, result cleared.
    drive(8'h30, 8'h2f, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", int'(bus.busy), 0);
    chk("rst_start_res", res3(), 0);
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("rst_start_no_done", dones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
